fp_result_unpacker: RTL
=======================

// Module: fp_result_unpacker
// PURPOSE
//  Receive end of the FP add/sub datapath. Accepts packed results (plus the op tag) on a
//  valid/ready stream and buffers them in a small FIFO. Splits each result into sign,
//  exponent and mantissa, classifies it, and keeps per-class event counters.
//  Sits between the add/sub core output and the result-checking/logging logic.
// PARAMETERS
//  WIDTH      32  packed FP word width
//  EXP_BITS    8  exponent field width
//  MANT_BITS  23  mantissa field width (WIDTH = 1 + EXP_BITS + MANT_BITS)
//  DEPTH       4  FIFO entries; power of two, >= 2
//  CNT_W      16  width of each class counter
// PORTS
//  clk              in   1          single clock, rising edge
//  rst_n            in   1          reset, asynchronous assert, active-low
//  in_valid         in   1          in_result/in_op are valid
//  in_ready         out  1          FIFO can accept (not full)
//  in_result        in   WIDTH      packed FP result
//  in_op            in   1          operation_select tag (0 add, 1 sub)
//  out_valid        out  1          FIFO head is valid
//  out_ready        in   1          consumer takes head
//  sign_result      out  1          head sign
//  exp_result       out  EXP_BITS   head exponent field
//  mantissa_result  out  MANT_BITS  head mantissa field
//  out_op           out  1          head op tag
//  out_class        out  3          head class (fp_class_e)
//  cnt_clear        in   1          synchronous clear of all counters
//  cnt_zero/cnt_denorm/cnt_inf/cnt_nan  out  CNT_W each  saturating class counts
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty, out_valid=0, in_ready=1.
//    All data outputs and all counters read 0.
//  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
//    Push and pop in the same cycle are both legal, and count is unchanged.
//  - in_ready=!full. It is a registered function of count, with no combinational path
//    from out_ready. When full, a pop frees a slot only on the next cycle.
//  - Latency: an item pushed at edge N is visible on out_* after edge N (out_valid next
//    cycle). There is no same-cycle bypass.
//  - Order is strictly FIFO. Pointers are log2(DEPTH)+1 bits with natural wrap;
//    full = MSBs differ and LSBs equal.
//  - Head outputs are stable while out_valid && !out_ready.
//  - Classification is decoded at push time and stored with each entry:
//      ZERO=0    exp==0, mant==0
//      DENORM=1  exp==0, mant!=0
//      NORMAL=2  0<exp<all-ones
//      INF=3     exp all-ones, mant==0
//      QNAN=4    exp all-ones, mant MSB=1
//      SNAN=5    exp all-ones, mant!=0, MSB=0
//  - Counters increment on push, by class. cnt_nan counts QNAN+SNAN; NORMAL is not counted.
//    Each counter saturates at all-ones and never wraps.
//  - cnt_clear with a push in the same cycle: counters reset to 0 and then count that
//    push, so the matching class reads 1 and all others read 0.
//  - Reset mid-operation discards all buffered entries; no partial output is produced.
//  - An in_valid held while full is not lost. It is accepted once in_ready returns.
// STRUCTURE
//  - fp_pkg holds:
//    - fp_class_e enum;
//    - WIDTH/EXP_BITS/MANT_BITS defaults;
//    - constants ZERO, NAN(7FC00000), INF(7F800000), NEG_INF(FF800000), MAX_POS(7F7FFFFF),
//      MAX_NEG, MIN_POS(00800000), MIN_NEG, MIN_POS_DENORM(00000001), MIN_NEG_DENORM.
//  - One combinational helper function, fp_classify(), lives in fp_pkg.
//  - One sub-module, fp_result_fifo: a generic DEPTH-entry sync FIFO with a payload of
//    {op, class, result}.
//  - Counters live in the top module.
// TESTING
//  1 in_result=7FC00000, out_ready=1 -> next cycle:
//    sign=0, exp=FF, mant=400000, class=QNAN, cnt_nan=1.
//  2 Push FF800000, then 80000000, then 00000001 -> classes INF(sign 1), ZERO(sign 1),
//    DENORM in order. Counters inf=1, zero=1, denorm=1.
//  3 out_ready=0, push 4 distinct values -> in_ready=0 after the 4th. The 5th is held.
//    Release out_ready -> 5 results drained in push order, none lost.
//  4 Count=1 with push and pop in the same cycle -> count stays 1.
//    out_valid stays 1 and the head advances correctly.
//  5 CNT_W=2: push 5 x 7F800001 (SNAN) -> cnt_nan=3 (saturated).
//    cnt_clear together with a 6th push -> cnt_nan=1.
//  6 2 entries queued, then rst_n pulsed low mid-cycle -> immediately out_valid=0,
//    in_ready=1, counters 0. Post-reset pushes behave as in test 1.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP field defaults, class encoding, reference constants and classifier.
package fp_pkg;
   localparam int FP_WIDTH     = 32;
   localparam int FP_EXP_BITS  = 8;
   localparam int FP_MANT_BITS = 23;
   typedef enum logic [2:0] {
      CLS_ZERO   = 3'd0,
      CLS_DENORM = 3'd1,
      CLS_NORMAL = 3'd2,
      CLS_INF    = 3'd3,
      CLS_QNAN   = 3'd4,
      CLS_SNAN   = 3'd5
   } fp_class_e;
   localparam logic [FP_WIDTH-1:0] ZERO           = 32'h0000_0000;
   localparam logic [FP_WIDTH-1:0] NAN            = 32'h7FC0_0000;
   localparam logic [FP_WIDTH-1:0] INF            = 32'h7F80_0000;
   localparam logic [FP_WIDTH-1:0] NEG_INF        = 32'hFF80_0000;
   localparam logic [FP_WIDTH-1:0] MAX_POS        = 32'h7F7F_FFFF;
   localparam logic [FP_WIDTH-1:0] MAX_NEG        = 32'hFF7F_FFFF;
   localparam logic [FP_WIDTH-1:0] MIN_POS        = 32'h0080_0000;
   localparam logic [FP_WIDTH-1:0] MIN_NEG        = 32'h8080_0000;
   localparam logic [FP_WIDTH-1:0] MIN_POS_DENORM = 32'h0000_0001;
   localparam logic [FP_WIDTH-1:0] MIN_NEG_DENORM = 32'h8000_0001;
   // Takes field summary flags so it serves any exponent/mantissa width.
   function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                             input logic mant_zero, input logic mant_msb);
      return exp_zero ? (mant_zero ? CLS_ZERO : CLS_DENORM) :
             !exp_ones ? CLS_NORMAL :
             mant_zero ? CLS_INF :
             mant_msb ? CLS_QNAN : CLS_SNAN;
   endfunction
endpackage

// File: rtl/fp_result_unpacker_if.sv
// fp_result_unpacker_if: result stream in, unpacked head out, class counters.
interface fp_result_unpacker_if import fp_pkg::*; #(
   parameter int WIDTH     = FP_WIDTH,
   parameter int EXP_BITS  = FP_EXP_BITS,
   parameter int MANT_BITS = FP_MANT_BITS,
   parameter int CNT_W     = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_result;
   logic                 in_op;
   logic                 out_valid;
   logic                 out_ready;
   logic                 sign_result;
   logic [EXP_BITS-1:0]  exp_result;
   logic [MANT_BITS-1:0] mantissa_result;
   logic                 out_op;
   fp_class_e            out_class;
   logic                 cnt_clear;
   logic [CNT_W-1:0]     cnt_zero;
   logic [CNT_W-1:0]     cnt_denorm;
   logic [CNT_W-1:0]     cnt_inf;
   logic [CNT_W-1:0]     cnt_nan;
   modport master (
      output in_valid, in_result, in_op, out_ready, cnt_clear,
      input  in_ready, out_valid, sign_result, exp_result, mantissa_result, out_op, out_class,
             cnt_zero, cnt_denorm, cnt_inf, cnt_nan
   );
   modport slave (
      input  in_valid, in_result, in_op, out_ready, cnt_clear,
      output in_ready, out_valid, sign_result, exp_result, mantissa_result, out_op, out_class,
             cnt_zero, cnt_denorm, cnt_inf, cnt_nan
   );
endinterface

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: DEPTH-entry synchronous FIFO; head reads 0 while empty.
module fp_result_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = wptr_q == rptr_q;
   assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
   always_comb begin
      wptr_d = (push_i && !full_o) ? wptr_q + 1'b1 : wptr_q;
      rptr_d = (pop_i && !empty_o) ? rptr_q + 1'b1 : rptr_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   always_ff @(posedge clk)
      if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/fp_result_unpacker.sv
// fp_result_unpacker: buffers add/sub results, classifies them at push time,
// presents the unpacked FIFO head and keeps saturating per-class counts.
module fp_result_unpacker import fp_pkg::*; #(
   parameter int WIDTH     = FP_WIDTH,
   parameter int EXP_BITS  = FP_EXP_BITS,
   parameter int MANT_BITS = FP_MANT_BITS,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   fp_result_unpacker_if.slave bus
);
   localparam int PW = WIDTH + 4;
   logic                 full, empty, push, pop;
   logic [EXP_BITS-1:0]  in_exp;
   logic [MANT_BITS-1:0] in_mant;
   fp_class_e            in_cls;
   logic [PW-1:0]        head;
   logic [CNT_W-1:0]     zero_q, zero_d, denorm_q, denorm_d, inf_q, inf_d, nan_q, nan_d;
   assign in_exp  = bus.in_result[WIDTH-2 -: EXP_BITS];
   assign in_mant = bus.in_result[MANT_BITS-1:0];
   assign in_cls  = fp_classify(in_exp == '0, &in_exp, in_mant == '0, in_mant[MANT_BITS-1]);
   assign push    = bus.in_valid && !full;
   assign pop     = bus.out_ready && !empty;
   fp_result_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({bus.in_op, in_cls, bus.in_result}),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign bus.in_ready        = !full;
   assign bus.out_valid       = !empty;
   assign bus.out_op          = head[PW-1];
   assign bus.out_class       = fp_class_e'(head[WIDTH +: 3]);
   assign bus.sign_result     = head[WIDTH-1];
   assign bus.exp_result      = head[WIDTH-2 -: EXP_BITS];
   assign bus.mantissa_result = head[MANT_BITS-1:0];
   // Clear happens first, so a push in the clear cycle lands on a zeroed counter.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
      logic [CNT_W-1:0] b;
      b = bus.cnt_clear ? '0 : c;
      return (en && !(&b)) ? b + 1'b1 : b;
   endfunction
   always_comb begin
      zero_d   = bump(zero_q, push && in_cls == CLS_ZERO);
      denorm_d = bump(denorm_q, push && in_cls == CLS_DENORM);
      inf_d    = bump(inf_q, push && in_cls == CLS_INF);
      nan_d    = bump(nan_q, push && (in_cls == CLS_QNAN || in_cls == CLS_SNAN));
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         zero_q   <= '0;
         denorm_q <= '0;
         inf_q    <= '0;
         nan_q    <= '0;
      end else begin
         zero_q   <= zero_d;
         denorm_q <= denorm_d;
         inf_q    <= inf_d;
         nan_q    <= nan_d;
      end
   assign bus.cnt_zero   = zero_q;
   assign bus.cnt_denorm = denorm_q;
   assign bus.cnt_inf    = inf_q;
   assign bus.cnt_nan    = nan_q;
endmodule
